uart_tx_fifo: RTL and testbench

//  SoC-side UART transmitter: buffers bytes from the CPU/MMIO bus in a small FIFO and serialises them

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and transmitter FSM encoding.
// The SoC UART receiver imports this package as well.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Fixed encodings so external tools and older code can decode the state bits.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// rd_data always shows the oldest entry while empty is low; rd_en pops it.
// Writes while full and reads while empty are ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_en,
    output logic                   full,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    // Storage array: written on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with byte FIFO: 8N1/8N2 frames, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits and the
// parity_odd input (0 = even, 1 = odd, sampled when the byte leaves the FIFO).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100,
    parameter int FIFO_DEPTH   = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [UART_DATA_W-1:0]      tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        tx_busy,
    output logic                        uart_tx
`ifdef UART_TX_PARITY_EN
    ,
    input  logic                        parity_odd
`endif
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    uart_tx_state_t         state;
    logic [BW-1:0]          baud_cnt;
    logic                   baud_end;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shifter;
    logic                   stop_idx;
    logic                   last_stop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_data;
    logic                   pop;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    uart_sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_data (tx_data),
        .wr_en   (tx_valid),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign tx_ready  = !fifo_full;
    assign tx_busy   = (state != IDLE) || !fifo_empty;
    assign baud_end  = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;

    // A byte leaves the FIFO when idle, or at the very end of the stop period so
    // the next start bit follows the stop bit with no idle gap.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || ((state == STOP) && baud_end && last_stop));

    // Frame sequencer: the baud counter restarts on every bit boundary and
    // uart_tx is registered, updated on the edge that enters each bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            uart_tx    <= 1'b1;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shifter    <= '0;
            stop_idx   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (pop) begin
            state      <= START;
            uart_tx    <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shifter    <= fifo_data;
            stop_idx   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^fifo_data) ^ parity_odd;
`endif
        end else begin
            case (state)
                IDLE: begin
                    uart_tx  <= 1'b1;
                    baud_cnt <= '0;
                end
                START: begin
                    if (baud_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        uart_tx  <= shifter[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            uart_tx  <= parity_bit;
`else
                            state    <= STOP;
                            uart_tx  <= 1'b1;
                            stop_idx <= 1'b0;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shifter <= shifter >> 1;
                            uart_tx <= shifter[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        state    <= STOP;
                        baud_cnt <= '0;
                        uart_tx  <= 1'b1;
                        stop_idx <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    uart_tx <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (last_stop) begin
                            state <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed pushes feed an expected-byte queue, a line
// monitor decodes frames from uart_tx and pops/compares independently.
module tb_uart_tx_fifo;

    localparam int CPB       = 100;
    localparam int DEPTH     = 16;
    localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (10 + STOP_BITS - 1 + PAR) * CPB;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [LW-1:0] fifo_level;
    logic          tx_busy;
    logic          uart_tx;
    logic          parity_odd;

    // {expected parity bit, expected data byte}
    logic [8:0] exp_q[$];
    int total  = 0;
    int bad    = 0;
    int cyc    = 0;
    int frames = 0;
    bit mon_en = 1'b0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .STOP_BITS    (STOP_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_level (fifo_level),
        .tx_busy    (tx_busy),
        .uart_tx    (uart_tx)
`ifdef UART_TX_PARITY_EN
        ,
        .parity_odd (parity_odd)
`endif
    );

    // Clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Offer one byte on one edge; returns the edge number it was presented on.
    task automatic push(input logic [7:0] d, input bit expect_it, input logic par, output int edge_n);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        if (expect_it) exp_q.push_back({par, d});
        @(posedge clk);
        #1;
        edge_n   = cyc;
        tx_valid = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Returns the edge after which tx_busy was first seen low (bounded).
    task automatic wait_idle(input int limit, output int when);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (!tx_busy) break;
        end
        when = cyc;
    endtask

    // Line monitor: decodes each frame at bit centres and scores it.
    initial begin
        logic       prev;
        logic [7:0] d;
        logic       p;
        logic [8:0] e;
        prev = 1'b1;
        d    = '0;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && prev && !uart_tx) begin
                repeat (CPB / 2) @(negedge clk);
                check("mon_start_bit", uart_tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                p = uart_tx;
`else
                p = 1'b0;
`endif
                for (int s = 0; s < STOP_BITS; s++) begin
                    repeat (CPB) @(negedge clk);
                    check("mon_stop_bit", uart_tx, 1);
                end
                frames++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_unexpected_frame: got data=0x%02h want none", d);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_frame_data", d, e[7:0]);
`ifdef UART_TX_PARITY_EN
                    check("mon_parity_bit", p, e[8]);
`endif
                end
                prev = uart_tx;
            end else begin
                prev = uart_tx;
            end
        end
    end

    // Directed stimulus
    initial begin
        int n, n2, when, lows;
        reset      = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = '0;
        parity_odd = 1'b0;

        // 1: reset held five cycles
        repeat (5) begin
            @(negedge clk);
            check("rst_uart_tx", uart_tx, 1);
            check("rst_tx_ready", tx_ready, 1);
            check("rst_tx_busy", tx_busy, 0);
            check("rst_fifo_level", fifo_level, 0);
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // 2: single byte 0x55, start on edge N+1, busy drops on edge ending stop
        push(8'h55, 1'b1, 1'b0, n);
        @(negedge clk);
        check("t2_level_after_push", fifo_level, 1);
        check("t2_line_still_idle", uart_tx, 1);
        check("t2_busy", tx_busy, 1);
        @(negedge clk);
        check("t2_start_edge_n1", uart_tx, 0);
        check("t2_level_after_pop", fifo_level, 0);
        wait_until(n + 1 + CPB);
        check("t2_bit0", uart_tx, 1);
        wait_until(n + 1 + 2 * CPB);
        check("t2_bit1", uart_tx, 0);
        wait_idle(FRAME + 200, when);
        check("t2_frame_len", when - n, FRAME + 1);
        repeat (5) @(negedge clk);

        // 3: 0x00 then 0xFF back-to-back, no idle gap between frames
        push(8'h00, 1'b1, 1'b0, n);
        push(8'hFF, 1'b1, 1'b0, n2);
        check("t3_consecutive_edges", n2 - n, 1);
        wait_until(n + FRAME);
        check("t3_first_stop", uart_tx, 1);
        @(negedge clk);
        check("t3_second_start", uart_tx, 0);
        wait_until(n + 1 + FRAME + CPB);
        check("t3_second_bit0", uart_tx, 1);
        wait_idle(2 * FRAME + 200, when);
        check("t3_two_frame_len", when - n, 2 * FRAME + 1);
        repeat (5) @(negedge clk);

        // 4: burst of 20 offers, 17 accepted, FIFO full until first frame ends
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tx_data  = 8'(8'h10 + i);
            tx_valid = 1'b1;
            check($sformatf("t4_ready_%0d", i), tx_ready, (i < 17) ? 1 : 0);
            if (i < 17) exp_q.push_back({^tx_data ^ parity_odd, tx_data});
            @(posedge clk);
            #1;
            if (i == 0) n = cyc;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("t4_level_full", fifo_level, 16);
        wait_until(n + FRAME);
        check("t4_ready_before_pop", tx_ready, 0);
        @(negedge clk);
        check("t4_ready_after_pop", tx_ready, 1);
        check("t4_level_after_pop", fifo_level, 15);
        wait_idle(17 * FRAME + 200, when);
        check("t4_burst_len", when - n, 17 * FRAME + 1);
        check("t4_frames_seen", frames, 20);
        check("t4_queue_drained", exp_q.size(), 0);
        repeat (5) @(negedge clk);

        // 5: reset at frame cycle 450 of 0xA3 with another byte queued
        mon_en = 1'b0;
        push(8'hA3, 1'b0, 1'b0, n);
        push(8'h3C, 1'b0, 1'b0, n2);
        wait_until(n + 450);
        check("t5_line_bit3_low", uart_tx, 0);
        check("t5_level_queued", fifo_level, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t5_line_high", uart_tx, 1);
        check("t5_level_cleared", fifo_level, 0);
        check("t5_busy_cleared", tx_busy, 0);
        check("t5_ready", tx_ready, 1);
        reset  = 1'b0;
        mon_en = 1'b1;
        lows   = 0;
        repeat (FRAME + 200) begin
            @(negedge clk);
            if (!uart_tx || tx_busy) lows++;
        end
        check("t5_no_further_frame", lows, 0);
        check("t5_frames_unchanged", frames, 20);

`ifdef UART_TX_PARITY_EN
        // 6: parity on 0x07, even then odd
        parity_odd = 1'b0;
        push(8'h07, 1'b1, 1'b1, n);
        wait_idle(FRAME + 200, when);
        check("t6_even_frame_len", when - n, 1101);
        repeat (5) @(negedge clk);
        parity_odd = 1'b1;
        push(8'h07, 1'b1, 1'b0, n);
        wait_until(n + 1 + 9 * CPB);
        check("t6_odd_parity_line", uart_tx, 0);
        wait_idle(FRAME + 200, when);
        check("t6_odd_frame_len", when - n, 1101);
        parity_odd = 1'b0;
`endif

        repeat (CPB) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
